// File: rtl/membrane_threshold_unit_if.sv
// Stream and status bundle between the partial-sum network, the threshold
// stage and the memory-controller path.
interface membrane_threshold_unit_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            timestep;
  logic                  done;
  logic                  err;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, timestep, done, err
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, timestep, done, err
  );
endinterface

// File: rtl/membrane_threshold_unit.sv
// Accumulates signed partial sums per neuron, fires against a threshold with
// subtractive reset, and emits one spike/potential packet per neuron per timestep.
module membrane_threshold_unit #(
  parameter int                     DATA_WIDTH    = 64,
  parameter int                     NUM_NEURONS   = 25,
  parameter int                     NUM_PARTIALS  = 5,
  parameter int                     NUM_TIMESTEPS = 10,
  parameter int                     POT_WIDTH     = 16,
  parameter logic signed [POT_WIDTH-1:0] THRESHOLD = 64,
  parameter logic [3:0]             MY_ADDR       = 4'b1110,
  parameter logic [3:0]             MEM_ADDR      = 4'b1101
) (
  input logic                      clk,
  input logic                      reset,
  membrane_threshold_unit_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int CNT_W = $clog2(NUM_PARTIALS);

  typedef logic signed [POT_WIDTH-1:0] pot_t;

  localparam pot_t              POT_MAX     = {1'b0, {(POT_WIDTH-1){1'b1}}};
  localparam pot_t              POT_MIN     = {1'b1, {(POT_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(NUM_PARTIALS - 1);
  localparam logic [IDX_W-1:0]  LAST_NEURON = IDX_W'(NUM_NEURONS - 1);
  localparam logic [3:0]        LAST_TS     = 4'(NUM_TIMESTEPS - 1);
  localparam logic [5:0]        N_LIMIT     = 6'(NUM_NEURONS);

  pot_t                  pot_q [NUM_NEURONS];
  logic [CNT_W-1:0]      cnt_q [NUM_NEURONS];
  logic [IDX_W-1:0]      fire_cnt_q, fire_cnt_d;
  logic [3:0]            ts_q, ts_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [3:0]            dest;
  logic [1:0]            ptype;
  logic [5:0]            n_fld;
  logic [IDX_W-1:0]      n_idx;
  pot_t                  ps;
  pot_t                  pot_rd;
  logic [CNT_W-1:0]      cnt_rd;
  logic [POT_WIDTH:0]    sum_ext;
  pot_t                  s;
  logic                  spike;
  logic                  in_ready;
  logic                  accept;
  logic                  pkt_ok;
  logic                  upd;
  logic                  fire;
  logic                  is_last;
  pot_t                  pot_wr_d;
  logic [CNT_W-1:0]      cnt_wr_d;
  logic                  unused_bits;

  assign dest    = bus.in_data[63:60];
  assign ptype   = bus.in_data[55:54];
  assign n_fld   = bus.in_data[53:48];
  assign n_idx   = n_fld[IDX_W-1:0];
  assign ps      = bus.in_data[POT_WIDTH-1:0];
  assign unused_bits = ^{bus.in_data[59:56], bus.in_data[47:POT_WIDTH]};

  assign pot_rd  = pot_q[n_idx];
  assign cnt_rd  = cnt_q[n_idx];

  // A fire may only happen when the output slot is empty or draining this cycle,
  // so a new packet can replace the departing one without a bubble.
  assign in_ready = !done_q && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign pkt_ok   = (dest == MY_ADDR) && (ptype == 2'b10) && (n_fld < N_LIMIT);
  assign upd      = accept && pkt_ok;
  assign is_last  = (cnt_rd == LAST_CNT);
  assign fire     = upd && is_last;

  always_comb begin
    sum_ext = {pot_rd[POT_WIDTH-1], pot_rd} + {ps[POT_WIDTH-1], ps};
    s       = pot_t'(sum_ext[POT_WIDTH-1:0]);
    if (sum_ext[POT_WIDTH] != sum_ext[POT_WIDTH-1]) begin
      s = sum_ext[POT_WIDTH] ? POT_MIN : POT_MAX;
    end
    spike    = (s >= THRESHOLD);
    pot_wr_d = (is_last && spike) ? pot_t'(s - THRESHOLD) : s;
    cnt_wr_d = is_last ? '0 : cnt_rd + 1'b1;
  end

  always_comb begin
    fire_cnt_d  = fire_cnt_q;
    ts_d        = ts_q;
    done_d      = done_q;
    err_d       = err_q | (accept && !pkt_ok);
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;

    if (fire) begin
      out_valid_d                     = 1'b1;
      out_data_d                      = '0;
      out_data_d[63:60]               = MEM_ADDR;
      out_data_d[59:56]               = MY_ADDR;
      out_data_d[55:54]               = 2'b11;
      out_data_d[53:48]               = n_fld;
      out_data_d[47:44]               = ts_q;
      out_data_d[16 +: POT_WIDTH]     = s;
      out_data_d[0]                   = spike;

      if (fire_cnt_q == LAST_NEURON) begin
        fire_cnt_d = '0;
        if (ts_q == LAST_TS) begin
          done_d = 1'b1;
        end else begin
          ts_d = ts_q + 4'd1;
        end
      end else begin
        fire_cnt_d = fire_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        pot_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      fire_cnt_q  <= '0;
      ts_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (upd) begin
        pot_q[n_idx] <= pot_wr_d;
        cnt_q[n_idx] <= cnt_wr_d;
      end
      fire_cnt_q  <= fire_cnt_d;
      ts_q        <= ts_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.timestep  = ts_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
